// File: rtl/tap_controller_if.sv
// TAP control bundle: tms into the controller, IR/DR cell controls out of it.
// Latency: n/a (wires only); backpressure: none, the TAP is free-running on tck.
// The master side is the controller and the slave side is the IR/DR cell array.
interface tap_controller_if;
   logic tms;
   logic reset_n;
   logic select;
   logic enable;
   logic capture_dr;
   logic shift_dr;
   logic update_dr;
   logic capture_ir;
   logic shift_ir;
   logic update_ir;

   modport master (
      input  tms,
      output reset_n,
      output select,
      output enable,
      output capture_dr,
      output shift_dr,
      output update_dr,
      output capture_ir,
      output shift_ir,
      output update_ir
   );

   modport slave (
      output tms,
      input  reset_n,
      input  select,
      input  enable,
      input  capture_dr,
      input  shift_dr,
      input  update_dr,
      input  capture_ir,
      input  shift_ir,
      input  update_ir
   );
endinterface

// File: rtl/tap_controller.sv
// JTAG TAP state machine; state moves on rising tck, controls register on falling tck.
// Latency: controls lag state entry by half a tck; no backpressure (tms is obeyed every cycle).
// Optional debug port state_o exists only when TAP_STATE_OUT_EN is defined.
module tap_controller (
   input  logic             tck,
   input  logic             trst_n,
   tap_controller_if.master tap
`ifdef TAP_STATE_OUT_EN
   ,
   output logic [3:0]       state_o
`endif
);

   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SH_DR    = 4'h2,
      EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR   = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SH_IR    = 4'hA,
      EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR   = 4'h8,
      UPD_IR   = 4'hD
   } state_t;

   state_t state_q;
   state_t state_d;

   logic reset_n_q;
   logic enable_q;
   logic capture_dr_q;
   logic shift_dr_q;
   logic capture_ir_q;
   logic shift_ir_q;
   logic select_c;

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         state_q <= TLR;
      end else begin
         state_q <= state_d;
      end
   end

   // All 16 codes are real states, so every value has a defined successor.
   always_comb begin
      state_d = TLR;
      case (state_q)
         TLR:      state_d = tap.tms ? TLR      : RTI;
         RTI:      state_d = tap.tms ? SEL_DR   : RTI;
         SEL_DR:   state_d = tap.tms ? SEL_IR   : CAP_DR;
         CAP_DR:   state_d = tap.tms ? EX1_DR   : SH_DR;
         SH_DR:    state_d = tap.tms ? EX1_DR   : SH_DR;
         EX1_DR:   state_d = tap.tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: state_d = tap.tms ? EX2_DR   : PAUSE_DR;
         EX2_DR:   state_d = tap.tms ? UPD_DR   : SH_DR;
         UPD_DR:   state_d = tap.tms ? SEL_DR   : RTI;
         SEL_IR:   state_d = tap.tms ? TLR      : CAP_IR;
         CAP_IR:   state_d = tap.tms ? EX1_IR   : SH_IR;
         SH_IR:    state_d = tap.tms ? EX1_IR   : SH_IR;
         EX1_IR:   state_d = tap.tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: state_d = tap.tms ? EX2_IR   : PAUSE_IR;
         EX2_IR:   state_d = tap.tms ? UPD_IR   : SH_IR;
         UPD_IR:   state_d = tap.tms ? SEL_DR   : RTI;
         default:  state_d = TLR;
      endcase
   end

   // Falling-edge registers give the cells a full half period of setup after a state change.
   always_ff @(negedge tck or negedge trst_n) begin
      if (!trst_n) begin
         reset_n_q    <= 1'b0;
         enable_q     <= 1'b0;
         capture_dr_q <= 1'b0;
         shift_dr_q   <= 1'b0;
         capture_ir_q <= 1'b0;
         shift_ir_q   <= 1'b0;
      end else begin
         reset_n_q    <= (state_q != TLR);
         enable_q     <= (state_q == SH_DR) || (state_q == SH_IR);
         capture_dr_q <= (state_q == CAP_DR);
         shift_dr_q   <= (state_q == SH_DR);
         capture_ir_q <= (state_q == CAP_IR);
         shift_ir_q   <= (state_q == SH_IR);
      end
   end

   always_comb begin
      select_c = 1'b0;
      case (state_q)
         CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR: select_c = 1'b1;
         default:                                         select_c = 1'b0;
      endcase
   end

   // state_q only changes while tck is high, so gating with ~tck hides any decode glitch.
   assign tap.update_dr  = (state_q == UPD_DR) & ~tck;
   assign tap.update_ir  = (state_q == UPD_IR) & ~tck;

   assign tap.reset_n    = reset_n_q;
   assign tap.enable     = enable_q;
   assign tap.capture_dr = capture_dr_q;
   assign tap.shift_dr   = shift_dr_q;
   assign tap.capture_ir = capture_ir_q;
   assign tap.shift_ir   = shift_ir_q;
   assign tap.select     = select_c;

`ifdef TAP_STATE_OUT_EN
   assign state_o = state_q;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: directed TAP sequences plus a random tms walk against a table-driven model.
module tb_tap_controller;

   localparam int S_TLR = 15, S_RTI = 12, S_SELDR = 7, S_CAPDR = 6, S_SHDR = 2, S_EX1DR = 1;
   localparam int S_PDR = 3, S_EX2DR = 0, S_UPDDR = 5, S_SELIR = 4, S_CAPIR = 14, S_SHIR = 10;
   localparam int S_EX1IR = 9, S_PIR = 11, S_EX2IR = 8, S_UPDIR = 13;

   logic tck;
   logic trst_n;
   tap_controller_if tif();
`ifdef TAP_STATE_OUT_EN
   logic [3:0] state_o;
`endif

   tap_controller dut (
      .tck    (tck),
      .trst_n (trst_n),
      .tap    (tif)
`ifdef TAP_STATE_OUT_EN
      ,
      .state_o(state_o)
`endif
   );

   int  n_checks;
   int  n_fail;
   int  nxt [16][2];
   bit  is_ir [16];
   int  m;
   bit  e_rstn, e_en, e_cdr, e_sdr, e_cir, e_sir;
   int  upd_ir_cnt, upd_dr_cnt;
   int  shdr_cnt, sel_cnt;
   int  exp_uir, exp_udr;
   logic [31:0] p_i;
   logic [31:0] ir_cell;
   bit  path [$];

   // Stand-in for update_ir_cell: loads the parallel input on the rising edge of update_ir.
   always @(posedge tif.update_ir) begin
      upd_ir_cnt <= upd_ir_cnt + 1;
      ir_cell    <= p_i;
   end
   always @(posedge tif.update_dr) upd_dr_cnt <= upd_dr_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic edge_def(input int s, input int n0, input int n1, input bit ir);
      nxt[s][0] = n0;
      nxt[s][1] = n1;
      is_ir[s]  = ir;
   endtask

   task automatic init_model();
      edge_def(S_TLR,   S_RTI,   S_TLR,   0);
      edge_def(S_RTI,   S_RTI,   S_SELDR, 0);
      edge_def(S_SELDR, S_CAPDR, S_SELIR, 0);
      edge_def(S_SELIR, S_CAPIR, S_TLR,   0);
      edge_def(S_CAPDR, S_SHDR,  S_EX1DR, 0);
      edge_def(S_SHDR,  S_SHDR,  S_EX1DR, 0);
      edge_def(S_EX1DR, S_PDR,   S_UPDDR, 0);
      edge_def(S_PDR,   S_PDR,   S_EX2DR, 0);
      edge_def(S_EX2DR, S_SHDR,  S_UPDDR, 0);
      edge_def(S_UPDDR, S_RTI,   S_SELDR, 0);
      edge_def(S_CAPIR, S_SHIR,  S_EX1IR, 1);
      edge_def(S_SHIR,  S_SHIR,  S_EX1IR, 1);
      edge_def(S_EX1IR, S_PIR,   S_UPDIR, 1);
      edge_def(S_PIR,   S_PIR,   S_EX2IR, 1);
      edge_def(S_EX2IR, S_SHIR,  S_UPDIR, 1);
      edge_def(S_UPDIR, S_RTI,   S_SELDR, 1);
   endtask

   task automatic check_common(input string ph);
      int act;
      check({ph, ".state"},   32'(dut.state_q), 32'(m));
`ifdef TAP_STATE_OUT_EN
      check({ph, ".state_o"}, 32'(state_o),     32'(m));
`endif
      check({ph, ".select"},     32'(tif.select),     32'(is_ir[m]));
      check({ph, ".reset_n"},    32'(tif.reset_n),    32'(e_rstn));
      check({ph, ".enable"},     32'(tif.enable),     32'(e_en));
      check({ph, ".capture_dr"}, 32'(tif.capture_dr), 32'(e_cdr));
      check({ph, ".shift_dr"},   32'(tif.shift_dr),   32'(e_sdr));
      check({ph, ".capture_ir"}, 32'(tif.capture_ir), 32'(e_cir));
      check({ph, ".shift_ir"},   32'(tif.shift_ir),   32'(e_sir));
      act = int'(tif.capture_dr) + int'(tif.shift_dr) + int'(tif.update_dr) +
            int'(tif.capture_ir) + int'(tif.shift_ir) + int'(tif.update_ir);
      check({ph, ".one_active"}, 32'(act <= 1), 32'd1);
   endtask

   task automatic tick(input bit t);
      tif.tms = t;
      #5 tck = 1'b1;
      m = nxt[m][t];
      #1;
      check_common("hi");
      check("hi.update_dr", 32'(tif.update_dr), 32'd0);
      check("hi.update_ir", 32'(tif.update_ir), 32'd0);
      #4 tck = 1'b0;
      e_rstn = (m != S_TLR);
      e_en   = (m == S_SHDR) || (m == S_SHIR);
      e_cdr  = (m == S_CAPDR);
      e_sdr  = (m == S_SHDR);
      e_cir  = (m == S_CAPIR);
      e_sir  = (m == S_SHIR);
      if (m == S_UPDIR) exp_uir++;
      if (m == S_UPDDR) exp_udr++;
      #1;
      check_common("lo");
      check("lo.update_dr", 32'(tif.update_dr), 32'(m == S_UPDDR));
      check("lo.update_ir", 32'(tif.update_ir), 32'(m == S_UPDIR));
      if (tif.shift_dr) shdr_cnt++;
      if (tif.select)   sel_cnt++;
      #4;
   endtask

   task automatic model_reset();
      m = S_TLR;
      {e_rstn, e_en, e_cdr, e_sdr, e_cir, e_sir} = '0;
   endtask

   task automatic pulse_reset();
      trst_n = 1'b0;
      #1;
      model_reset();
      check_common("rst");
      check("rst.update_dr", 32'(tif.update_dr), 32'd0);
      check("rst.update_ir", 32'(tif.update_ir), 32'd0);
      #1 trst_n = 1'b1;
   endtask

   // Shortest tms sequence from TLR to the target, found by breadth-first search of the model graph.
   task automatic find_path(input int target);
      int  q [$];
      int  prev [16];
      int  ptms [16];
      bit  seen [16];
      int  s, n;
      path.delete();
      foreach (seen[i]) seen[i] = 0;
      q.push_back(S_TLR);
      seen[S_TLR] = 1;
      while (q.size() > 0) begin
         s = q.pop_front();
         for (int b = 0; b < 2; b++) begin
            n = nxt[s][b];
            if (!seen[n]) begin
               seen[n] = 1;
               prev[n] = s;
               ptms[n] = b;
               q.push_back(n);
            end
         end
      end
      s = target;
      while (s != S_TLR) begin
         path.push_front(ptms[s][0]);
         s = prev[s];
      end
   endtask

   task automatic goto_state(input int target);
      pulse_reset();
      find_path(target);
      foreach (path[i]) tick(path[i]);
   endtask

   initial begin
      int uir0, udr0;
      n_checks = 0;
      n_fail   = 0;
      upd_ir_cnt = 0;
      upd_dr_cnt = 0;
      exp_uir = 0;
      exp_udr = 0;
      ir_cell = '0;
      p_i     = '0;
      tck     = 1'b0;
      trst_n  = 1'b1;
      tif.tms = 1'b1;
      init_model();
      #2;

      // Reset, then one tms=0 clock into Run-Test/Idle.
      pulse_reset();
      tick(0);
      check("rti.state", 32'(dut.state_q), 32'hC);
      check("rti.reset_n", 32'(tif.reset_n), 32'd1);

      // IR scan: capture, shift, update loads the IR cell.
      p_i  = $urandom;
      uir0 = upd_ir_cnt;
      tick(1); tick(1); tick(0);
      check("ir.capture_ir", 32'(tif.capture_ir), 32'd1);
      tick(0);
      check("ir.shift_ir", 32'(tif.shift_ir), 32'd1);
      check("ir.enable",   32'(tif.enable),   32'd1);
      check("ir.select",   32'(tif.select),   32'd1);
      tick(1); tick(1);
      tick(0);
      check("ir.upd_pulses", 32'(upd_ir_cnt - uir0), 32'd1);
      check("ir.cell", ir_cell, p_i);

      // DR scan with a pause in the middle.
      shdr_cnt = 0;
      sel_cnt  = 0;
      udr0     = upd_dr_cnt;
      begin
         bit seq [11] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1};
         foreach (seq[i]) tick(seq[i]);
      end
      check("dr.state_upd", 32'(dut.state_q), 32'h5);
      check("dr.shift_edges", 32'(shdr_cnt), 32'd4);
      check("dr.upd_pulses", 32'(upd_dr_cnt - udr0), 32'd1);
      check("dr.select_hi", 32'(sel_cnt), 32'd0);

      // Five tms=1 clocks reach Test-Logic-Reset from every state.
      for (int s = 0; s < 16; s++) begin
         goto_state(s);
         check("walk.at_state", 32'(dut.state_q), 32'(s));
         for (int k = 0; k < 5; k++) tick(1);
         check("tlr5.state", 32'(dut.state_q), 32'hF);
         check("tlr5.reset_n", 32'(tif.reset_n), 32'd0);
      end

      // Asynchronous reset while tck is high, just after leaving Shift-IR.
      goto_state(S_SHIR);
      uir0 = upd_ir_cnt;
      tif.tms = 1'b1;
      #5 tck = 1'b1;
      m = nxt[m][1];
      #2 trst_n = 1'b0;
      #1;
      model_reset();
      check("arst.state",    32'(dut.state_q),  32'hF);
      check("arst.shift_ir", 32'(tif.shift_ir), 32'd0);
      check("arst.enable",   32'(tif.enable),   32'd0);
      check("arst.reset_n",  32'(tif.reset_n),  32'd0);
      #2 tck = 1'b0;
      #1;
      check_common("arst_lo");
      check("arst_lo.update_ir", 32'(tif.update_ir), 32'd0);
      #3 trst_n = 1'b1;
      #1;
      check("arst.no_upd_ir", 32'(upd_ir_cnt - uir0), 32'd0);
      #2;

      // Random walk over the whole graph.
      pulse_reset();
      exp_uir = 0;
      exp_udr = 0;
      uir0 = upd_ir_cnt;
      udr0 = upd_dr_cnt;
      for (int i = 0; i < 600; i++) begin
         p_i = $urandom;
         tick($urandom_range(0, 2) == 0);
      end
      #1;
      check("rnd.upd_ir_pulses", 32'(upd_ir_cnt - uir0), 32'(exp_uir));
      check("rnd.upd_dr_pulses", 32'(upd_dr_cnt - udr0), 32'(exp_udr));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 tck  input  1  test clock; the only clock; state register on rising edge, control outputs on falling edge.
REQ-003 trst_n  input  1  test reset, asynchronous, active-low.
REQ-004 tms  input  1  test mode select, sampled on rising tck.
REQ-005 reset_n  output  1  active-low reset to IR/DR cells; 0 while in Test-Logic-Reset.
REQ-006 select  output  1  TDO mux select: 1 = IR path, 0 = DR path.
REQ-007 enable  output  1  TDO output enable; 1 only while shifting.
REQ-008 capture_dr, shift_dr, update_dr  output  1 each  DR-path controls.
REQ-009 capture_ir, shift_ir, update_ir  output  1 each  IR-path controls; update_ir clocks update_ir_cell on its rising edge.
REQ-010 state_o  output  4  current state encoding; present only with TAP_STATE_OUT_EN.

Function
REQ-011 The state register SHALL be 4 bits with encodings: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAUSE_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAUSE_IR=B, EX2_IR=8, UPD_IR=D.
REQ-012 Transitions on rising tck SHALL be written as (tms=0 / tms=1): TLR RTI/TLR; RTI RTI/SEL_DR; SEL_DR CAP_DR/SEL_IR; SEL_IR CAP_IR/TLR.
REQ-013 For x in {DR, IR}, transitions SHALL be: CAP_x SH_x/EX1_x; SH_x SH_x/EX1_x; EX1_x PAUSE_x/UPD_x; PAUSE_x PAUSE_x/EX2_x; EX2_x SH_x/UPD_x; UPD_x RTI/SEL_DR.
REQ-014 Five consecutive rising tck with tms=1 SHALL reach TLR from any state.
REQ-015 On each falling tck, reset_n SHALL register (state!=TLR); capture_x SHALL register (state==CAP_x); shift_x SHALL register (state==SH_x); enable SHALL register (state==SH_DR or state==SH_IR).
REQ-016 update_x SHALL be high exactly while state==UPD_x and tck==0, giving one pulse per UPD_x visit whose rising edge coincides with falling tck; it SHALL be glitch-free, decoded from registered state and qualified only by tck.
REQ-017 select SHALL be combinational from state: 1 in CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR; 0 otherwise.
REQ-018 Control outputs SHALL therefore lag state entry by half a tck period.
REQ-019 At most one of the capture/shift/update outputs SHALL be high at any time.
REQ-020 An unreachable or corrupt state value SHALL NOT occur: all 16 codes are legal and REQ-012/013 fully define the next state.

Reset
REQ-021 trst_n low SHALL immediately force state=TLR, reset_n=0, enable=0, and all capture/shift outputs 0, independent of tck.
REQ-022 update_ir and update_dr SHALL be 0 during reset; no update pulse SHALL be generated by reset assertion mid-operation, e.g. while in SH_IR.
REQ-023 After trst_n deasserts, the first rising tck SHALL apply REQ-012 from TLR.
REQ-024 reset_n SHALL return to 1 on the first falling tck after the state leaves TLR.

Configuration
REQ-025 Macro TAP_STATE_OUT_EN SHALL gate the debug port.
REQ-026 When TAP_STATE_OUT_EN is defined, port state_o SHALL exist and equal the state register.
REQ-027 When TAP_STATE_OUT_EN is undefined, the port SHALL be absent, with no other change to behaviour or timing.

Verification
REQ-028 Bench SHALL cover: trst_n=0, then release and clock tms=0 -> state RTI (C); reset_n=1 after the following falling tck.
REQ-029 Bench SHALL cover: from RTI, tms 1,1,0,0 -> CAP_IR (capture_ir 1 for one cycle), then SH_IR (shift_ir=1, enable=1, select=1); tms 1,1 -> one update_ir pulse during tck low in UPD_IR; update_ir_cell loads p_i.
REQ-030 Bench SHALL cover: from RTI, tms 1,0,0,0,0,1,0,1,0,1,1 -> DR shift for 3 cycles, PAUSE_DR, back to SH_DR, then UPD_DR -> shift_dr high 4 falling edges total, one update_dr pulse, select=0 throughout.
REQ-031 Bench SHALL cover: from each of the 16 states, tms=1 for 5 rising edges -> TLR (F), reset_n=0.
REQ-032 Bench SHALL cover: trst_n pulsed low mid-SH_IR while tck=1 -> state F, shift_ir=0, enable=0 immediately, update_ir never pulses.
REQ-033 Bench SHALL cover: with TAP_STATE_OUT_EN defined, walk the full graph -> state_o matches the REQ-011 codes each cycle; without it, the build elaborates with no state_o port.
